ysyx_25020037_axi_rd_rsp: RTL
=============================

YSYX_25020037_AXI_RD_RSP -- requirements
Module: ysyx_25020037_axi_rd_rsp

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'hA0000000, lowest decoded byte address.
REQ-002 SHALL have parameter MEM_SIZE, default 32'h02000000, decoded window size in bytes.
REQ-003 SHALL have parameter LATENCY, default 2, extra wait cycles inserted before every beat's memory read, range 0-15.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have AR ports: arvalid in 1; arready out 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2.
REQ-007 SHALL have R ports: rvalid out 1; rready in 1; rdata out 32; rresp out 2; rlast out 1; rid out 4.
REQ-008 SHALL have memory ports: mem_en out 1, read strobe; mem_addr out 32, word-aligned byte address; mem_rdata in 32, valid the cycle after mem_en.

Function
REQ-009 SHALL implement states IDLE, WAIT, FETCH and RESP; in IDLE, arready = 1; in every other state, arready = 0.
REQ-010 IDLE SHALL accept AR on arvalid&&arready and latch addr, id, len, size and burst; it SHALL then go to WAIT, load the wait counter with LATENCY, and clear the beat counter.
REQ-011 WAIT: if the counter is 0, SHALL go to FETCH; otherwise SHALL decrement.
REQ-012 FETCH SHALL assert mem_en for exactly 1 cycle with mem_addr = {beat_addr[31:2],2'b00}, unless the burst is errored, and SHALL then go to RESP.
REQ-013 In RESP, rdata SHALL equal mem_rdata, captured the cycle after FETCH, or 0 if errored.
REQ-014 RESP SHALL assert rvalid, with rdata, rresp, rid and rlast stable, until rready.
REQ-015 rlast SHALL be 1 iff beat_cnt == latched arlen.
REQ-016 On rvalid&&rready with rlast = 1, SHALL go to IDLE, and rvalid SHALL be 0 next cycle.
REQ-017 On rvalid&&rready with rlast = 0, SHALL increment beat_cnt, advance beat_addr, reload the counter and go to WAIT.
REQ-018 Timing: AR handshake at cycle N SHALL produce first rvalid at N+3+LATENCY.
REQ-019 Timing: R handshake at cycle M on a non-last beat SHALL produce the next rvalid at M+3+LATENCY.
REQ-020 Address advance: INCR (2'b01) SHALL add 4 per beat, mod 2^32; FIXED (2'b00) SHALL keep the address.
REQ-021 Address advance: WRAP (2'b10) and reserved (2'b11) SHALL be treated as errored.
REQ-022 Error classification at AR accept: start address outside [MEM_BASE, MEM_BASE+MEM_SIZE) SHALL give DECERR (2'b11).
REQ-023 Error classification at AR accept: arsize != 3'd2, or an unsupported burst type, SHALL give SLVERR (2'b10); DECERR takes priority over SLVERR.
REQ-024 Error classification per beat: an INCR beat crossing the top of the window SHALL give DECERR for that beat and all following beats.
REQ-025 Errored bursts SHALL still return exactly arlen+1 beats, each with rdata = 0, no mem_en, the error rresp, and the correct rlast.
REQ-026 Non-errored beats SHALL return rresp = 2'b00.
REQ-027 rid SHALL equal the latched arid on every beat of a burst.
REQ-028 No new AR SHALL be accepted until the previous burst's last beat handshakes; single outstanding transaction only.
REQ-029 arvalid asserted while busy SHALL be ignored and left pending, with no state change.
REQ-030 The beat counter SHALL be 8 bits, supporting arlen = 255 (256 beats) without overflow.
REQ-031 The wait counter SHALL be 4 bits.
REQ-032 rvalid SHALL never depend combinationally on rready; arready SHALL never depend combinationally on arvalid.

Reset
REQ-033 rst high SHALL immediately force state IDLE.
REQ-034 rst high SHALL immediately force arready = 0 while rst is high, and arready = 1 the first cycle after release.
REQ-035 rst high SHALL immediately force rvalid = 0, rlast = 0, rresp = 2'b00, rdata = 0 and rid = 0.
REQ-036 rst high SHALL immediately force mem_en = 0 and mem_addr = 0, and clear all counters and latches.
REQ-037 Reset mid-burst SHALL abandon the burst with no further beats; the first post-reset AR SHALL be served normally.

Verification
REQ-038 Single read: LATENCY=2, araddr=32'hA0000010, arlen=0, arburst=0, arid=3, mem word 32'h12345678 -> one beat at N+5 with rdata=32'h12345678, rresp=0, rlast=1, rid=3.
REQ-039 INCR burst: araddr=32'hA0000000, arlen=3, arburst=1 -> mem_addr A0000000, A0000004, A0000008, A000000C, 4 beats, rlast only on the 4th.
REQ-040 Backpressure: rready held low 7 cycles on beat 1 of a 2-beat burst -> rdata and rlast stable, no second mem_en until the handshake.
REQ-041 Decode error: araddr=32'h80000000, arlen=1 -> 2 beats, rresp=2'b11, rdata=0, mem_en never asserted.
REQ-042 Bad size and window crossing: arsize=3'd1 -> single SLVERR beat; INCR at MEM_BASE+MEM_SIZE-4 with arlen=1 -> beat 0 OKAY, beat 1 DECERR.
REQ-043 Mid-burst reset: rst pulsed during beat 2 of an arlen=3 burst -> rvalid=0 immediately, arready=1 after release, next AR returns correct data.

Source files
------------

// File: rtl/ysyx_25020037_axi_rd_rsp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020037_axi_rd_rsp
// Brief    : AXI4 read-channel slave serving one burst at a time from a
//            word-wide synchronous memory port, with decode/slave error replies.
// Revision : 1.0
// ============================================================================
module ysyx_25020037_axi_rd_rsp #(
  parameter logic [31:0] MEM_BASE = 32'hA0000000,
  parameter logic [31:0] MEM_SIZE = 32'h02000000,
  parameter int          LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  // AR channel
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // R channel
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  // memory port
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] c_mem_end = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  localparam logic [3:0]  c_latency = 4'(LATENCY);
  localparam logic [1:0]  c_okay    = 2'b00;
  localparam logic [1:0]  c_slverr  = 2'b10;
  localparam logic [1:0]  c_decerr  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [3:0]  r_id;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_beat;
  logic [3:0]  r_wait;
  logic        r_dec;
  logic        r_fresh;
  logic [31:0] r_hold;

  logic        w_in_window;
  logic [32:0] w_addr_inc;
  logic        w_cross;
  logic        w_last;
  logic [1:0]  w_beat_resp;

  assign w_in_window = (araddr >= MEM_BASE) && ({1'b0, araddr} < c_mem_end);
  assign w_addr_inc  = {1'b0, r_addr} + 33'd4;
  assign w_cross     = (w_addr_inc >= c_mem_end);
  assign w_last      = (r_beat == r_len);
  // Decode errors are sticky and outrank the burst-wide size/type error.
  assign w_beat_resp = r_dec ? c_decerr :
                       ((r_size != 3'd2) || r_burst[1]) ? c_slverr : c_okay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_dec   <= 1'b0;
      r_fresh <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (arvalid) begin
            r_addr  <= araddr;
            r_id    <= arid;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
            r_wait  <= c_latency;
            r_dec   <= !w_in_window;
          end
        end
        S_WAIT: begin
          if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
        end
        S_FETCH: r_fresh <= 1'b1;
        S_RESP: begin
          // Memory data is only valid for one cycle; keep it for backpressure.
          if (r_fresh) begin
            r_hold  <= mem_rdata;
            r_fresh <= 1'b0;
          end
          if (rready && !w_last) begin
            r_beat <= r_beat + 8'd1;
            r_wait <= c_latency;
            if (r_burst == 2'b01) begin
              r_addr <= w_addr_inc[31:0];
              if (w_cross) r_dec <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rresp    = c_okay;
    rdata    = '0;
    rid      = r_id;
    mem_en   = 1'b0;
    mem_addr = '0;
    case (r_state)
      S_IDLE: begin
        arready = !rst;
        if (arvalid) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait == 4'd0) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_beat_resp == c_okay) begin
          mem_en   = 1'b1;
          mem_addr = {r_addr[31:2], 2'b00};
        end
        w_next = S_RESP;
      end
      S_RESP: begin
        rvalid = 1'b1;
        rlast  = w_last;
        rresp  = w_beat_resp;
        if (w_beat_resp == c_okay) rdata = r_fresh ? mem_rdata : r_hold;
        if (rready) w_next = w_last ? S_IDLE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
